// File: rtl/mem_byte_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_byte_seq_if                                           |
// | Purpose  : CPU-side request/response bundle of the byte sequencer    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface mem_byte_seq_if #(
    parameter int ADDR_W = 11
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_byte_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_byte_seq                                              |
// | Purpose  : 32-bit load/store to byte-serial RAM access sequencer     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mem_byte_seq #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 1536
) (
    input  wire                clk,
    input  wire                rst_n,
    mem_byte_seq_if.slave      bus,
    output logic               ram_re,
    output logic [ADDR_W-1:0]  ram_raddr,
    input  wire  [7:0]         ram_rdata,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_waddr,
    output logic [7:0]         ram_wdata
);

    localparam logic [ADDR_W:0] c_DEPTH_EXT = DEPTH[ADDR_W:0];

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_last;
    logic [1:0]        r_cnt;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_we;
    logic              r_err;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_cap_en;
    logic [1:0]        r_cap_idx;

    logic [1:0]        w_nbytes_m1;
    logic [ADDR_W:0]   w_end;
    logic              w_req_err;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr_cur;
    logic [7:0]        w_wlane;
    logic [31:0]       w_ext;

    always_comb begin
        w_nbytes_m1 = 2'd0;
        case (bus.req_size)
            2'b01:   w_nbytes_m1 = 2'd1;
            2'b10:   w_nbytes_m1 = 2'd3;
            default: w_nbytes_m1 = 2'd0;
        endcase
        // One extra bit so a request near the top of the address space cannot wrap.
        w_end     = {1'b0, bus.req_addr} + {{(ADDR_W-1){1'b0}}, w_nbytes_m1};
        w_req_err = (bus.req_size == 2'b11) || (w_end >= c_DEPTH_EXT);
        w_accept  = bus.req_valid && (r_state == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)       w_state_nxt = S_ERR;
                    else if (bus.req_we) w_state_nxt = S_WRITE;
                    else                 w_state_nxt = S_READ;
                end
            end
            S_WRITE: if (r_cnt == r_last) w_state_nxt = S_RESP;
            S_READ:  if (r_cnt == r_last) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_RESP;
            S_ERR:   w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_last     <= 2'd0;
            r_cnt      <= 2'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_cap_en   <= 1'b0;
            r_cap_idx  <= 2'd0;
        end else begin
            // RAM data arrives one edge after the issue, so remember which lane it belongs to.
            r_cap_en  <= (r_state == S_READ);
            r_cap_idx <= r_cnt;
            if (w_accept) begin
                r_base     <= bus.req_addr;
                r_last     <= w_nbytes_m1;
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
                r_we       <= bus.req_we;
                r_err      <= w_req_err;
                r_wdata    <= bus.req_wdata;
                r_rdata    <= 32'd0;
                r_cnt      <= 2'd0;
            end else begin
                if ((r_state == S_WRITE) || (r_state == S_READ)) begin
                    r_cnt <= r_cnt + 2'd1;
                end
                if (r_cap_en) begin
                    case (r_cap_idx)
                        2'd0:    r_rdata[7:0]   <= ram_rdata;
                        2'd1:    r_rdata[15:8]  <= ram_rdata;
                        2'd2:    r_rdata[23:16] <= ram_rdata;
                        default: r_rdata[31:24] <= ram_rdata;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_addr_cur = r_base + ADDR_W'(r_cnt);
        case (r_cnt)
            2'd0:    w_wlane = r_wdata[7:0];
            2'd1:    w_wlane = r_wdata[15:8];
            2'd2:    w_wlane = r_wdata[23:16];
            default: w_wlane = r_wdata[31:24];
        endcase
        case (r_size)
            2'b00:   w_ext = {{24{~r_unsigned & r_rdata[7]}},  r_rdata[7:0]};
            2'b01:   w_ext = {{16{~r_unsigned & r_rdata[15]}}, r_rdata[15:0]};
            default: w_ext = r_rdata;
        endcase

        ram_we         = (r_state == S_WRITE);
        ram_waddr      = ram_we ? w_addr_cur : '0;
        ram_wdata      = ram_we ? w_wlane : 8'd0;
        ram_re         = (r_state == S_READ);
        ram_raddr      = ram_re ? w_addr_cur : '0;
        bus.resp_valid = (r_state == S_RESP);
        bus.resp_err   = (r_state == S_RESP) && r_err;
        bus.resp_rdata = ((r_state == S_RESP) && !r_err && !r_we) ? w_ext : 32'd0;
        bus.req_ready  = (r_state == S_IDLE) && rst_n;
    end

endmodule
`default_nettype wire

// File: doc/mem_byte_seq.md
# mem_byte_seq

Load/store sequencer that turns 32-bit CPU data accesses into byte-serial accesses on the banked 1536x8 data RAM. It sits between the core's load/store stage and the RAM wrapper, whose read and write ports share one clock. The sequencer:
- drives the RAM's read and write ports;
- handles the RAM's one-cycle read latency;
- assembles little-endian results with sign or zero extension;
- rejects out-of-range accesses without touching the RAM.

## Interface
Parameters:
- ADDR_W, 11, byte-address width.
- DEPTH, 1536, number of implemented bytes; valid addresses are 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address of the lowest byte.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data; bits [8n-1:0] are used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid: request rejected.
- resp_rdata  out  32  valid with resp_valid on loads; 0 for stores and errors.
- ram_re, ram_raddr[ADDR_W-1:0]  out  RAM read enable and address.
- ram_rdata  in  8  RAM read data, valid one edge after ram_re.
- ram_we, ram_waddr[ADDR_W-1:0], ram_wdata[7:0]  out  RAM write enable, address and data.

## Operation
- Byte count n = 1, 2 or 4 from req_size. Byte i uses address req_addr+i and data lane [8i+7:8i] (little-endian). Misaligned accesses are legal.
- Request, address, size, unsigned flag and data are latched on the accept edge (req_valid & req_ready).
- States:
  - IDLE → ERR if req_size = 11 or req_addr + n - 1 >= DEPTH (sum computed at ADDR_W+1 bits, so there is no wrap-around).
  - IDLE → WRITE on a legal store; IDLE → READ on a legal load.
  - WRITE: one byte per cycle, ram_we=1, ram_waddr=base+cnt, ram_wdata=lane cnt. After byte n-1 → RESP.
  - READ: one issue per cycle, ram_re=1, ram_raddr=base+cnt. The byte issued in cycle k is captured from ram_rdata into lane k in cycle k+1. After the last issue → DRAIN, which captures the final byte → RESP.
  - ERR: no RAM strobe; → RESP with the error flag set.
  - RESP: resp_valid=1 for one cycle → IDLE.
- Load result: bytes above n are filled with 0 if req_unsigned=1, otherwise with bit 8n-1. A word load ignores req_unsigned.
- ram_re, ram_we and the address/data outputs are decoded from registered state. The RAM addresses are 0 and ram_re/ram_we are 0 in any state that does not use them.
- Reset is asynchronous:
  - state goes to IDLE and all outputs go to 0 except req_ready, which is 1 after reset is released;
  - bytes already written by an aborted store remain in the RAM; no response is issued for the aborted request.

## Timing
Counting from the accept edge E0:
- Store: writes occur at E1..En; resp_valid is high in the cycle between En and En+1. A word store completes after E4.
- Load: issues are sampled at E1..En and the last capture occurs at En+1; resp_valid is high between En+1 and En+2. A word load completes after E5; a byte load after E2.
- Error: resp_valid is high between E1 and E2.
- req_ready is low from E0 until resp_valid has dropped. The minimum request spacing is n+2 cycles for a store and n+3 cycles for a load.

## Test plan
- Word store 0x11223344 to address 0x010, then word load from 0x010: RAM writes 0x44, 0x33, 0x22, 0x11 at 0x010..0x013 on E1..E4. The load returns resp_rdata=0x11223344 after E5 with resp_err=0.
- Byte load from 0x011 after storing 0x80 there: sign-extended load returns 0xFFFFFF80; zero-extended load returns 0x00000080.
- Misaligned half store 0xBEEF at 0x1FF (crosses bank 0/1): bytes 0xEF at 0x1FF and 0xBE at 0x200. A half load from 0x1FF with req_unsigned=0 returns 0xFFFFBEEF.
- Word load at 0x5FD: resp_err=1 after E1, ram_re is never asserted, resp_rdata=0. A word load at 0x5FC succeeds. req_size=11 also produces an error.
- Hold req_valid high with back-to-back stores: req_ready stays low for the whole sequence, and no second request is accepted before resp_valid has pulsed.
- Assert rst_n low after E2 of a word store: outputs clear immediately and no resp_valid follows. RAM bytes 0 and 1 hold the new data; bytes 2 and 3 hold the old data.
